// File: rtl/dmem_responder_if.sv
// Request/response channel between the RV32I MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = AW + 2;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic          lat_we;
  logic [LW-1:0] lat_addr;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [31:0]   lat_wdata;

  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:LW];

  logic accept, go_resp;
  assign accept  = bus.req_valid && (state == ST_IDLE);
  assign go_resp = ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                   ((state == ST_WAIT) && (cnt == '0));

  // With zero wait states the commit coincides with accept, so decode from the bus in IDLE.
  logic          cur_we, cur_unsigned;
  logic [LW-1:0] cur_addr;
  logic [1:0]    cur_size;
  logic [31:0]   cur_wdata;
  assign cur_we       = (state == ST_IDLE) ? bus.req_we           : lat_we;
  assign cur_addr     = (state == ST_IDLE) ? bus.req_addr[LW-1:0] : lat_addr;
  assign cur_size     = (state == ST_IDLE) ? bus.req_size         : lat_size;
  assign cur_unsigned = (state == ST_IDLE) ? bus.req_unsigned     : lat_unsigned;
  assign cur_wdata    = (state == ST_IDLE) ? bus.req_wdata        : lat_wdata;

  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  assign idx     = cur_addr[LW-1:2];
  assign rd_word = mem[idx];

  logic [1:0]  off;
  logic        err;
  logic [3:0]  strb;
  logic [31:0] wrep;
  logic [31:0] rext;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    off  = cur_addr[1:0];
    err  = 1'b0;
    strb = 4'b0000;
    wrep = cur_wdata;
    rext = 32'h0;
    case (cur_size)
      2'b00: begin
        strb = 4'b0001 << off;
        wrep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        if (off[0]) err = 1'b1;
`else
        off = {off[1], 1'b0};
`endif
        strb = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        if (off != 2'b00) err = 1'b1;
`else
        off = 2'b00;
`endif
        strb = 4'b1111;
      end
      default: err = 1'b1;
    endcase
    if (err) strb = 4'b0000;

    sel_b = rd_word[8*off +: 8];
    sel_h = off[1] ? rd_word[31:16] : rd_word[15:0];
    if (!err && !cur_we) begin
      case (cur_size)
        2'b00:   rext = {{24{~cur_unsigned & sel_b[7]}}, sel_b};
        2'b01:   rext = {{16{~cur_unsigned & sel_h[15]}}, sel_h};
        default: rext = rd_word;
      endcase
    end
  end

  // NOTE: the storage array has no reset; reset only guards against committing an in-flight store.
  always_ff @(posedge clk) begin
    if (!reset && go_resp && cur_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we       <= bus.req_we;
            lat_addr     <= bus.req_addr[LW-1:0];
            lat_size     <= bus.req_size;
            lat_unsigned <= bus.req_unsigned;
            lat_wdata    <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (go_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rext;
        rsp_err_q   <= err;
      end
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES = 2; expected values are hand-computed.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issues one request and returns once rsp_valid is seen (response not yet consumed).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, output int lat);
    int guard;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // Full transaction with rsp_ready held high: response is consumed on the next edge.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
    int lat;
    issue(we, addr, size, uns, wdata, lat);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_data"}, bus.rsp_rdata, exp_data);
    check({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [31:0] held;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, bus.rsp_err},   32'd0);

    xact("sw10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    xact("sw20",  1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0);
    xact("sb21",  1'b1, 32'h21, 2'b00, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0);
    xact("lb21",  1'b0, 32'h21, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu21", 1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);
    xact("lw20",  1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h11228044, 1'b0);
    xact("lh20",  1'b0, 32'h20, 2'b01, 1'b0, 32'h0, 32'hFFFF8044, 1'b0);
    xact("lhu20", 1'b0, 32'h20, 2'b01, 1'b1, 32'h0, 32'h00008044, 1'b0);

    // Backpressure: response must hold for five cycles, then retire on the first ready cycle.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat);
    check("bp_lat", lat, 3);
    held = bus.rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("bp_ready", {31'b0, bus.req_ready}, 32'd0);
      check("bp_data",  bus.rsp_rdata, held);
    end
    check("bp_value", held, 32'hDEADBEEF);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("bp_done_ready", {31'b0, bus.req_ready}, 32'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
    xact("lh23", 1'b0, 32'h23, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("lw22", 1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
`else
    xact("lh23", 1'b0, 32'h23, 2'b01, 1'b0, 32'h0, 32'h00001122, 1'b0);
    xact("lw22", 1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 32'h11228044, 1'b0);
`endif

    xact("ill_ld", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("ill_st", 1'b1, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("lw10b",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("wrap",   1'b0, 32'h410, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset while a store sits in WAIT: the store must not land.
    xact("sw40z", 1'b1, 32'h40, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_size  = 2'b10;
    bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mid_ready_lo", {31'b0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_idle", {31'b0, bus.req_ready}, 32'd1);
    check("mid_valid", {31'b0, bus.rsp_valid}, 32'd0);
    xact("lw40", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset coinciding with a request: the request is dropped.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'hCAFEF00D;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rw_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rw_ready", {31'b0, bus.req_ready}, 32'd1);
    xact("lw40b", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
